// File: rtl/rsa_encoder.sv
// Fixed-key RSA encryption engine: c = m^e mod n by left-to-right Montgomery exponentiation.
// A single bit-serial radix-2 Montgomery multiplier is shared by every step; each product takes k+1 cycles.
module rsa_encoder #(
    parameter int            k      = 12,
    parameter int            logk   = 4,
    parameter logic [k-1:0]  n      = 12'd3551,
    parameter logic [k-1:0]  e      = 12'd5,
    parameter logic [k-1:0]  exp_2k = 12'd2292
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [k-1:0] data_in,
    output logic [k-1:0] data_out,
    output logic         done,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_M,
        S_PRE_A,
        S_SQR,
        S_MUL,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [k-1:0]    ONE    = {{(k-1){1'b0}}, 1'b1};
    localparam logic [k+1:0]    N_EXT  = {2'b00, n};
    localparam logic [logk-1:0] K_LAST = logk'(k - 1);

    state_t          state_q;
    logic [k-1:0]    m_q;
    logic [k-1:0]    m_bar_q;
    logic [k-1:0]    acc_q;
    logic [k-1:0]    data_out_q;
    logic [k+1:0]    u_q;
    logic [logk-1:0] j_q;
    logic [logk-1:0] i_q;
    logic            sub_q;
    logic            done_q;
    logic            busy_q;

    logic [k-1:0]    a_sel;
    logic [k-1:0]    b_sel;
    logic [k+1:0]    sum;
    logic [k+1:0]    sum_odd;
    logic [k+1:0]    u_d;
    logic [k-1:0]    mm_res;

    // acc_q and m_bar_q only change on a subtract cycle, so operands stay stable across one product.
    always_comb begin
        a_sel = acc_q;
        b_sel = acc_q;
        case (state_q)
            S_PRE_M: begin
                a_sel = m_q;
                b_sel = exp_2k;
            end
            S_PRE_A: begin
                a_sel = ONE;
                b_sel = exp_2k;
            end
            S_MUL:   b_sel = m_bar_q;
            S_POST:  b_sel = ONE;
            default: ;
        endcase
        sum     = u_q + (a_sel[j_q] ? {2'b00, b_sel} : '0);
        sum_odd = sum + (sum[0] ? N_EXT : '0);
        u_d     = sum_odd >> 1;
        mm_res  = k'((u_q >= N_EXT) ? (u_q - N_EXT) : u_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            m_bar_q    <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            u_q        <= '0;
            j_q        <= '0;
            i_q        <= '0;
            sub_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        m_q     <= data_in;
                        i_q     <= K_LAST;
                        u_q     <= '0;
                        j_q     <= '0;
                        sub_q   <= 1'b0;
                        state_q <= S_PRE_M;
                    end
                end
                S_DONE: begin
                    data_out_q <= acc_q;
                    done_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    if (!sub_q) begin
                        u_q <= u_d;
                        if (j_q == K_LAST) begin
                            sub_q <= 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        // Final conditional subtract; the next product starts on the following cycle.
                        u_q   <= '0;
                        j_q   <= '0;
                        sub_q <= 1'b0;
                        case (state_q)
                            S_PRE_M: begin
                                m_bar_q <= mm_res;
                                state_q <= S_PRE_A;
                            end
                            S_PRE_A: begin
                                acc_q   <= mm_res;
                                state_q <= S_SQR;
                            end
                            S_SQR: begin
                                acc_q <= mm_res;
                                if (e[i_q]) begin
                                    state_q <= S_MUL;
                                end else if (i_q == '0) begin
                                    state_q <= S_POST;
                                end else begin
                                    i_q <= i_q - 1'b1;
                                end
                            end
                            S_MUL: begin
                                acc_q <= mm_res;
                                if (i_q == '0) begin
                                    state_q <= S_POST;
                                end else begin
                                    i_q     <= i_q - 1'b1;
                                    state_q <= S_SQR;
                                end
                            end
                            S_POST: begin
                                acc_q   <= mm_res;
                                state_q <= S_DONE;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rsa_encoder.sv
// Bench for rsa_encoder: a cycle-level reference model (accept time + fixed latency + modexp result)
// is checked against busy/done/data_out every cycle, plus directed and randomized transactions.
module tb_rsa_encoder;

    localparam int K    = 12;
    localparam int NMOD = 3551;
    localparam int EXP  = 5;
    localparam int LAT  = (K + 3 + $countones(EXP)) * (K + 1) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [K-1:0]  data_in = '0;
    logic [K-1:0]  data_out;
    logic          done;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    bit            chk_en = 1'b0;

    bit            m_run = 1'b0;
    int            m_cnt = 0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [K-1:0]  m_dout = '0;
    logic [K-1:0]  m_pend = '0;

    logic [K-1:0]  res;
    int            lat;
    int            ndone;
    int            cyc;
    int            last;
    logic [K-1:0]  dec;

    rsa_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned modexp(input longint unsigned base, input longint unsigned ex, input int bits);
        longint unsigned r = 1;
        longint unsigned b = base % NMOD;
        for (int i = bits - 1; i >= 0; i--) begin
            r = (r * r) % NMOD;
            if (ex[i]) r = (r * b) % NMOD;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
        end
    endtask

    // Reference model: an accepted request completes exactly LAT edges later with (m mod n)^e mod n.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run  = 1'b0;
                m_cnt  = 0;
                m_busy = 1'b0;
                m_done = 1'b0;
                m_dout = '0;
            end else begin
                m_done = 1'b0;
                if (!m_run) begin
                    m_busy = start;
                    if (start) begin
                        m_run  = 1'b1;
                        m_cnt  = 0;
                        m_pend = K'(modexp(data_in, EXP, K));
                    end
                end else begin
                    m_cnt++;
                    if (m_cnt == LAT) begin
                        m_done = 1'b1;
                        m_dout = m_pend;
                        m_run  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) check("cycle{busy,done,data_out}", {busy, done, data_out}, {m_busy, m_done, m_dout});
        end
    end

    task automatic run_op(input logic [K-1:0] m, input int glitch, output logic [K-1:0] r, output int l);
        @(negedge clk);
        start   = 1'b1;
        data_in = m;
        @(posedge clk);
        #1;
        l = 0;
        while (l < 1000) begin
            @(negedge clk);
            start   = (l == glitch);
            data_in = K'($urandom);
            @(posedge clk);
            #1;
            l++;
            if (done) break;
        end
        r = data_out;
        $display("op m=%0d c=%0d latency=%0d", m, r, l);
    endtask

    initial begin
        logic [K-1:0] vec_m [7];
        logic [K-1:0] vec_c [7];
        vec_m = '{12'd2, 12'd10, 12'd100, 12'd0, 12'd1, 12'd3561, 12'd4095};
        vec_c = '{12'd32, 12'd572, 12'd492, 12'd0, 12'd1, 12'd572, 12'd0};
        vec_c[6] = K'(modexp(544, EXP, K));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_outputs", {busy, done, data_out}, '0);

        for (int t = 0; t < 7; t++) begin
            run_op(vec_m[t], -1, res, lat);
            check("vector_result", res, vec_c[t]);
            check("vector_latency", lat, LAT);
        end

        // A start pulse while busy must not spawn a second operation.
        run_op(12'd77, 50, res, lat);
        check("glitch_result", res, K'(modexp(77, EXP, K)));
        check("glitch_latency", lat, LAT);
        ndone = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("glitch_extra_done", ndone, 0);

        @(negedge clk);
        start   = 1'b1;
        data_in = 12'd123;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("busy_mid_op", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {busy, done, data_out}, '0);
        @(negedge clk);
        rst = 1'b0;
        run_op(12'd10, -1, res, lat);
        check("after_reset_result", res, 12'd572);
        check("after_reset_latency", lat, LAT);

        dec = K'(modexp(2959, 1373, K));
        run_op(dec, -1, res, lat);
        check("round_trip", res, 12'd2959);

        @(negedge clk);
        start   = 1'b1;
        data_in = 12'd2;
        ndone = 0;
        cyc = 0;
        last = 0;
        while (ndone < 3 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                if (ndone > 0) check("hold_gap", cyc - last, LAT + 1);
                check("hold_result", data_out, 12'd32);
                $display("op hold m=2 c=%0d cycle=%0d", data_out, cyc);
                last = cyc;
                ndone++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("hold_done_count", ndone, 3);

        for (int t = 0; t < 200; t++) begin
            logic [K-1:0] m;
            m = K'($urandom_range(0, 4095));
            run_op(m, -1, res, lat);
            check("random_result", res, K'(modexp(m, EXP, K)));
            check("random_latency", lat, LAT);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
